vga_depth_reducer: RTL and testbench

Parametrised video colour-depth reduction stage between the core RGB outputs and a narrow board-level video DAC (e.g. 2-bit-per-channel PMOD VGA).
Generalises the fixed 3-to-2-bit high/low select to any IN_BITS-to-OUT_BITS reduction with four modes: low-bits, high-bits, rounding and 4x4 ordered (Bayer) dither with optional per-frame temporal rotation.
Mode changes are frame-synchronous. Syncs are delayed to stay aligned with the pixel pipeline.

---
 rtl/vga_depth_pkg.sv | 32 +++
 rtl/vga_depth_reducer_if.sv | 31 +++
 rtl/vga_depth_chan.sv | 42 ++++
 rtl/vga_depth_reducer.sv | 107 ++++++++++
 tb/tb_vga_depth_reducer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_depth_pkg.sv
// Shared definitions for the colour-depth reducer: mode encoding, the 4x4
// ordered-dither matrix and the saturating right shift used by round/dither.
package vga_depth_pkg;

  typedef enum logic [1:0] {
    MODE_LOW    = 2'd0,
    MODE_HIGH   = 2'd1,
    MODE_ROUND  = 2'd2,
    MODE_DITHER = 2'd3
  } mode_t;

  // Working width of the saturating helper; covers IN_BITS up to 8.
  localparam int SAT_W = 9;

  localparam logic [3:0] BAYER [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  function automatic logic [SAT_W-1:0] sat_shift(input logic [SAT_W-1:0] sum,
                                                 input int shift,
                                                 input int out_bits);
    logic [SAT_W-1:0] q;
    logic [SAT_W-1:0] lim;
    q   = sum >> shift;
    lim = SAT_W'((1 << out_bits) - 1);
    return (q > lim) ? lim : q;
  endfunction

endpackage

// File: rtl/vga_depth_reducer_if.sv
// Video bundle between the core RGB/sync outputs and the reducer, plus the
// reduced colour and delayed syncs going out to the board DAC.
interface vga_depth_reducer_if #(
  parameter int IN_BITS  = 3,
  parameter int OUT_BITS = 2
);
  logic                pix_ce_i;
  logic [IN_BITS-1:0]  rgb_r_i;
  logic [IN_BITS-1:0]  rgb_g_i;
  logic [IN_BITS-1:0]  rgb_b_i;
  logic                blank_i;
  logic                hsync_i;
  logic                vsync_i;
  logic [1:0]          mode_i;
  logic [1:0]          mode_o;
  logic [OUT_BITS-1:0] rgb_r_o;
  logic [OUT_BITS-1:0] rgb_g_o;
  logic [OUT_BITS-1:0] rgb_b_o;
  logic                hsync_o;
  logic                vsync_o;

  modport master (
    output pix_ce_i, rgb_r_i, rgb_g_i, rgb_b_i, blank_i, hsync_i, vsync_i, mode_i,
    input  mode_o, rgb_r_o, rgb_g_o, rgb_b_o, hsync_o, vsync_o
  );

  modport slave (
    input  pix_ce_i, rgb_r_i, rgb_g_i, rgb_b_i, blank_i, hsync_i, vsync_i, mode_i,
    output mode_o, rgb_r_o, rgb_g_o, rgb_b_o, hsync_o, vsync_o
  );
endinterface

// File: rtl/vga_depth_chan.sv
// Per-channel colour reduction: low bits, high bits, rounding or ordered
// dither, with saturation so full-scale inputs never wrap to zero.
module vga_depth_chan
  import vga_depth_pkg::*;
#(
  parameter int IN_BITS  = 3,
  parameter int OUT_BITS = 2
) (
  input  logic [IN_BITS-1:0]  v,
  input  logic [3:0]          bayer,
  input  mode_t               mode,
  output logic [OUT_BITS-1:0] res
);
  localparam int D  = IN_BITS - OUT_BITS;
  localparam int SW = IN_BITS + 1;

  logic [3:0]       t;
  logic [SW-1:0]    sum_round;
  logic [SW-1:0]    sum_dith;
  logic [SAT_W-1:0] sat_round;
  logic [SAT_W-1:0] sat_dith;

  // Keep only the top D bits of the 4-bit threshold so it matches the
  // weight of the bits being discarded.
  assign t         = bayer >> (4 - D);
  assign sum_round = SW'(v) + SW'(1 << (D - 1));
  assign sum_dith  = SW'(v) + SW'(t);
  assign sat_round = sat_shift(SAT_W'(sum_round), D, OUT_BITS);
  assign sat_dith  = sat_shift(SAT_W'(sum_dith), D, OUT_BITS);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves res unassigned (no latch).
    res = '0;
    unique case (mode)
      MODE_LOW:    res = v[OUT_BITS-1:0];
      MODE_HIGH:   res = OUT_BITS'(v >> D);
      MODE_ROUND:  res = sat_round[OUT_BITS-1:0];
      MODE_DITHER: res = sat_dith[OUT_BITS-1:0];
    endcase
  end

endmodule

// File: rtl/vga_depth_reducer.sv
// Two-stage colour-depth reducer: stage 1 captures pixel, syncs and screen
// position; stage 2 reduces each channel and registers the outputs.
module vga_depth_reducer
  import vga_depth_pkg::*;
#(
  parameter int IN_BITS  = 3,
  parameter int OUT_BITS = 2,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int MODE_RST = 1,
  parameter int TEMPORAL = 0
) (
  input logic               clk_i,
  input logic               reset_i,
  vga_depth_reducer_if.slave vid
);
  localparam logic  HS_ACT    = 1'(HS_POL);
  localparam logic  VS_ACT    = 1'(VS_POL);
  localparam mode_t MODE_INIT = mode_t'(2'(MODE_RST));

  logic hs_act, vs_act, hs_prev, vs_prev, hs_edge, vs_edge;
  logic [1:0] x_q, y_q, frame_q, xx, yy;
  mode_t mode_q;

  logic [IN_BITS-1:0] r1, g1, b1;
  logic               blank1, hs1, vs1;
  logic [1:0]         x1, y1;

  logic [3:0]          bayer;
  logic [OUT_BITS-1:0] r_c, g_c, b_c, r_q, g_q, b_q;
  logic                hs_q, vs_q;

  assign hs_act  = (vid.hsync_i == HS_ACT);
  assign vs_act  = (vid.vsync_i == VS_ACT);
  assign hs_edge = hs_act & ~hs_prev;
  assign vs_edge = vs_act & ~vs_prev;

  // Temporal mode slides the threshold pattern by the frame count (2-bit wrap).
  assign xx    = (TEMPORAL != 0) ? x1 + frame_q : x1;
  assign yy    = (TEMPORAL != 0) ? y1 + {1'b0, frame_q[1]} : y1;
  assign bayer = BAYER[yy][xx];

  vga_depth_chan #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_chan_r (
    .v(r1), .bayer(bayer), .mode(mode_q), .res(r_c));
  vga_depth_chan #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_chan_g (
    .v(g1), .bayer(bayer), .mode(mode_q), .res(g_c));
  vga_depth_chan #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_chan_b (
    .v(b1), .bayer(bayer), .mode(mode_q), .res(b_c));

  // NOTE: non-blocking assignments so every stage samples last cycle's state, not this cycle's update.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      x_q     <= 2'd0;
      y_q     <= 2'd0;
      frame_q <= 2'd0;
      mode_q  <= MODE_INIT;
      r1      <= '0;
      g1      <= '0;
      b1      <= '0;
      blank1  <= 1'b0;
      hs1     <= ~HS_ACT;
      vs1     <= ~VS_ACT;
      x1      <= 2'd0;
      y1      <= 2'd0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= ~HS_ACT;
      vs_q    <= ~VS_ACT;
    end else if (vid.pix_ce_i) begin
      hs_prev <= hs_act;
      vs_prev <= vs_act;
      x_q     <= hs_edge ? 2'd0 : x_q + 2'd1;
      if (vs_edge)      y_q <= 2'd0;
      else if (hs_edge) y_q <= y_q + 2'd1;
      if (vs_edge) begin
        frame_q <= frame_q + 2'd1;
        mode_q  <= mode_t'(vid.mode_i);
      end

      r1     <= vid.rgb_r_i;
      g1     <= vid.rgb_g_i;
      b1     <= vid.rgb_b_i;
      blank1 <= vid.blank_i;
      hs1    <= vid.hsync_i;
      vs1    <= vid.vsync_i;
      x1     <= x_q;
      y1     <= y_q;

      r_q  <= blank1 ? '0 : r_c;
      g_q  <= blank1 ? '0 : g_c;
      b_q  <= blank1 ? '0 : b_c;
      hs_q <= hs1;
      vs_q <= vs1;
    end
  end

  assign vid.mode_o  = mode_q;
  assign vid.rgb_r_o = r_q;
  assign vid.rgb_g_o = g_q;
  assign vid.rgb_b_o = b_q;
  assign vid.hsync_o = hs_q;
  assign vid.vsync_o = vs_q;

endmodule

// File: tb/tb_vga_depth_reducer.sv
// Scoreboard bench for vga_depth_reducer: a default instance and a temporal
// dither instance share one stimulus stream and are checked against a model.
module tb_vga_depth_reducer;
  localparam int IN_B  = 3;
  localparam int OUT_B = 2;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       hs;
    logic       vs;
  } exp_t;

  localparam exp_t RST_EXP = '{r: 2'd0, g: 2'd0, b: 2'd0, hs: 1'b1, vs: 1'b1};

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  vga_depth_reducer_if #(.IN_BITS(IN_B), .OUT_BITS(OUT_B)) vif ();
  vga_depth_reducer_if #(.IN_BITS(IN_B), .OUT_BITS(OUT_B)) vif_t ();

  assign vif_t.pix_ce_i = vif.pix_ce_i;
  assign vif_t.rgb_r_i  = vif.rgb_r_i;
  assign vif_t.rgb_g_i  = vif.rgb_g_i;
  assign vif_t.rgb_b_i  = vif.rgb_b_i;
  assign vif_t.blank_i  = vif.blank_i;
  assign vif_t.hsync_i  = vif.hsync_i;
  assign vif_t.vsync_i  = vif.vsync_i;
  assign vif_t.mode_i   = vif.mode_i;

  vga_depth_reducer #(
    .IN_BITS(IN_B), .OUT_BITS(OUT_B), .HS_POL(0), .VS_POL(0), .MODE_RST(1), .TEMPORAL(0)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .vid(vif)
  );

  vga_depth_reducer #(
    .IN_BITS(IN_B), .OUT_BITS(OUT_B), .HS_POL(0), .VS_POL(0), .MODE_RST(3), .TEMPORAL(1)
  ) dut_t (
    .clk_i(clk_i), .reset_i(reset_i), .vid(vif_t)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t last0, last1;

  int bay[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  logic [1:0] m_x, m_y, m_f;
  logic       m_hs_prev, m_vs_prev;
  int         m_mode[2];

  function automatic int reduce(int v, int mode, int xx, int yy);
    int d;
    int mx;
    int s;
    d  = IN_B - OUT_B;
    mx = (1 << OUT_B) - 1;
    case (mode)
      0:       s = v & mx;
      1:       s = v >> d;
      2:       s = (v + (1 << (d - 1))) >> d;
      default: s = (v + (bay[yy & 3][xx & 3] >> (4 - d))) >> d;
    endcase
    if (s > mx) s = mx;
    return s;
  endfunction

  task automatic model_reset();
    m_x = 2'd0; m_y = 2'd0; m_f = 2'd0;
    m_hs_prev = 1'b0; m_vs_prev = 1'b0;
    m_mode[0] = 1; m_mode[1] = 3;
  endtask

  // One enabled pixel: apply it, advance the model, queue both expected outputs.
  task automatic drive(input int r, input int g, input int b, input logic blank,
                       input logic hs, input logic vs, input int mode);
    int   xp, yp;
    logic he, ve;
    exp_t e;
    vif.pix_ce_i = 1'b1;
    vif.rgb_r_i  = 3'(r);
    vif.rgb_g_i  = 3'(g);
    vif.rgb_b_i  = 3'(b);
    vif.blank_i  = blank;
    vif.hsync_i  = hs;
    vif.vsync_i  = vs;
    vif.mode_i   = 2'(mode);
    he = (hs == 1'b0) && !m_hs_prev;
    ve = (vs == 1'b0) && !m_vs_prev;
    m_hs_prev = (hs == 1'b0);
    m_vs_prev = (vs == 1'b0);
    xp = int'(m_x);
    yp = int'(m_y);
    m_x = he ? 2'd0 : m_x + 2'd1;
    if (ve)      m_y = 2'd0;
    else if (he) m_y = m_y + 2'd1;
    if (ve) begin
      m_f = m_f + 2'd1;
      m_mode[0] = mode;
      m_mode[1] = mode;
    end
    for (int i = 0; i < 2; i++) begin
      int xx;
      int yy;
      xx = xp + ((i == 1) ? int'(m_f) : 0);
      yy = yp + ((i == 1) ? int'(m_f[1]) : 0);
      e.r  = blank ? 2'd0 : 2'(reduce(r, m_mode[i], xx, yy));
      e.g  = blank ? 2'd0 : 2'(reduce(g, m_mode[i], xx, yy));
      e.b  = blank ? 2'd0 : 2'(reduce(b, m_mode[i], xx, yy));
      e.hs = hs;
      e.vs = vs;
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      vif.pix_ce_i = 1'b0;
      vif.rgb_r_i  = 3'($urandom);
      vif.rgb_g_i  = 3'($urandom);
      vif.rgb_b_i  = 3'($urandom);
      vif.blank_i  = 1'($urandom);
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic frame_start(input int mode);
    drive(0, 0, 0, 1'b1, 1'b0, 1'b0, mode);
  endtask

  task automatic line_start(input int mode);
    drive(0, 0, 0, 1'b1, 1'b0, 1'b1, mode);
  endtask

  task automatic do_reset(input int cycles);
    reset_i = 1'b1;
    model_reset();
    repeat (cycles) @(posedge clk_i);
    #2;
  endtask

  // Scoreboard: each enabled edge retires one queued pixel; idle edges must hold.
  always @(posedge clk_i) begin
    logic ce;
    logic rst;
    exp_t g0, g1, e0, e1;
    ce  = vif.pix_ce_i;
    rst = reset_i;
    #1;
    g0 = {vif.rgb_r_o, vif.rgb_g_o, vif.rgb_b_o, vif.hsync_o, vif.vsync_o};
    g1 = {vif_t.rgb_r_o, vif_t.rgb_g_o, vif_t.rgb_b_o, vif_t.hsync_o, vif_t.vsync_o};
    if (rst) begin
      q0.delete(); q1.delete();
      q0.push_back(RST_EXP); q1.push_back(RST_EXP);
      last0 = RST_EXP; last1 = RST_EXP;
    end else if (ce) begin
      total++;
      if (q0.size() == 0) begin
        bad++; $display("FAIL sb_main underflow at %0t", $time);
      end else begin
        e0 = q0.pop_front();
        last0 = e0;
        if (g0 !== e0) begin
          bad++; $display("FAIL sb_main got=%h want=%h at %0t", g0, e0, $time);
        end
      end
      total++;
      if (q1.size() == 0) begin
        bad++; $display("FAIL sb_temporal underflow at %0t", $time);
      end else begin
        e1 = q1.pop_front();
        last1 = e1;
        if (g1 !== e1) begin
          bad++; $display("FAIL sb_temporal got=%h want=%h at %0t", g1, e1, $time);
        end
      end
    end else begin
      total++;
      if (g0 !== last0) begin
        bad++; $display("FAIL hold_main got=%h want=%h at %0t", g0, last0, $time);
      end
      total++;
      if (g1 !== last1) begin
        bad++; $display("FAIL hold_temporal got=%h want=%h at %0t", g1, last1, $time);
      end
    end
  end

  task automatic test_reset();
    vif.pix_ce_i = 1'b1; vif.blank_i = 1'b1; vif.hsync_i = 1'b1; vif.vsync_i = 1'b1;
    vif.rgb_r_i = 3'd7; vif.rgb_g_i = 3'd7; vif.rgb_b_i = 3'd7; vif.mode_i = 2'd2;
    do_reset(3);
    total++;
    if ({vif.rgb_r_o, vif.rgb_g_o, vif.rgb_b_o} !== 6'd0) begin
      bad++; $display("FAIL reset_rgb got=%h want=0", {vif.rgb_r_o, vif.rgb_g_o, vif.rgb_b_o});
    end
    total++;
    if ({vif.hsync_o, vif.vsync_o} !== 2'b11) begin
      bad++; $display("FAIL reset_sync got=%b want=11", {vif.hsync_o, vif.vsync_o});
    end
    total++;
    if (vif.mode_o !== 2'd1) begin
      bad++; $display("FAIL reset_mode got=%0d want=1", vif.mode_o);
    end
    total++;
    if (vif_t.mode_o !== 2'd3) begin
      bad++; $display("FAIL reset_mode_t got=%0d want=3", vif_t.mode_o);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_latency();
    drive(6, 0, 0, 1'b0, 1'b0, 1'b1, 1);
    total++;
    if ({vif.rgb_r_o, vif.hsync_o} !== 3'b001) begin
      bad++; $display("FAIL latency_early got=%b want=001", {vif.rgb_r_o, vif.hsync_o});
    end
    drive(0, 0, 0, 1'b0, 1'b1, 1'b1, 1);
    total++;
    if ({vif.rgb_r_o, vif.hsync_o} !== 3'b110) begin
      bad++; $display("FAIL latency_arrive got=%b want=110", {vif.rgb_r_o, vif.hsync_o});
    end
    drive(0, 0, 0, 1'b1, 1'b1, 1'b1, 1);
  endtask

  task automatic test_modes();
    frame_start(0);
    total++;
    if (vif.mode_o !== 2'd0) begin
      bad++; $display("FAIL mode_low_latch got=%0d want=0", vif.mode_o);
    end
    drive(6, 5, 3, 1'b0, 1'b1, 1'b1, 0);
    drive(1, 2, 3, 1'b0, 1'b1, 1'b1, 0);
    total++;
    if (vif.rgb_r_o !== 2'b10) begin
      bad++; $display("FAIL mode_low got=%b want=10", vif.rgb_r_o);
    end
    frame_start(2);
    total++;
    if (vif.mode_o !== 2'd2) begin
      bad++; $display("FAIL mode_round_latch got=%0d want=2", vif.mode_o);
    end
    drive(5, 4, 2, 1'b0, 1'b1, 1'b1, 2);
    drive(7, 7, 7, 1'b0, 1'b1, 1'b1, 2);
    total++;
    if (vif.rgb_r_o !== 2'b11) begin
      bad++; $display("FAIL mode_round got=%b want=11", vif.rgb_r_o);
    end
    drive(0, 0, 0, 1'b1, 1'b1, 1'b1, 2);
    total++;
    if (vif.rgb_r_o !== 2'b11) begin
      bad++; $display("FAIL mode_round_sat got=%b want=11", vif.rgb_r_o);
    end
  endtask

  task automatic test_dither();
    logic [1:0] row0[4];
    logic [1:0] row1[4];
    row0 = '{2'd1, 2'd2, 2'd1, 2'd2};
    row1 = '{2'd2, 2'd1, 2'd2, 2'd1};
    frame_start(3);
    for (int k = 0; k < 4; k++) begin
      drive(3, 3, 3, 1'b0, 1'b1, 1'b1, 3);
      if (k > 0) begin
        total++;
        if (vif.rgb_r_o !== row0[k-1]) begin
          bad++; $display("FAIL dither_y0 x=%0d got=%0d want=%0d", k - 1, vif.rgb_r_o, row0[k-1]);
        end
      end
    end
    line_start(3);
    total++;
    if (vif.rgb_r_o !== row0[3]) begin
      bad++; $display("FAIL dither_y0 x=3 got=%0d want=%0d", vif.rgb_r_o, row0[3]);
    end
    for (int k = 0; k < 4; k++) begin
      drive(3, 3, 3, 1'b0, 1'b1, 1'b1, 3);
      if (k > 0) begin
        total++;
        if (vif.rgb_r_o !== row1[k-1]) begin
          bad++; $display("FAIL dither_y1 x=%0d got=%0d want=%0d", k - 1, vif.rgb_r_o, row1[k-1]);
        end
      end
    end
    drive(0, 0, 0, 1'b1, 1'b1, 1'b1, 3);
    total++;
    if (vif.rgb_r_o !== row1[3]) begin
      bad++; $display("FAIL dither_y1 x=3 got=%0d want=%0d", vif.rgb_r_o, row1[3]);
    end
  endtask

  task automatic test_temporal();
    vif.pix_ce_i = 1'b1; vif.blank_i = 1'b1; vif.hsync_i = 1'b1; vif.vsync_i = 1'b1;
    do_reset(1);
    reset_i = 1'b0;
    drive(3, 3, 3, 1'b0, 1'b1, 1'b1, 3);
    drive(0, 0, 0, 1'b1, 1'b1, 1'b1, 3);
    total++;
    if (vif_t.rgb_r_o !== 2'd1) begin
      bad++; $display("FAIL temporal_frame0 got=%0d want=1", vif_t.rgb_r_o);
    end
    frame_start(3);
    drive(3, 3, 3, 1'b0, 1'b1, 1'b1, 3);
    drive(0, 0, 0, 1'b1, 1'b1, 1'b1, 3);
    total++;
    if (vif_t.rgb_r_o !== 2'd2) begin
      bad++; $display("FAIL temporal_frame1 got=%0d want=2", vif_t.rgb_r_o);
    end
  endtask

  task automatic test_mode_switch();
    frame_start(1);
    total++;
    if (vif.mode_o !== 2'd1) begin
      bad++; $display("FAIL switch_start got=%0d want=1", vif.mode_o);
    end
    for (int k = 0; k < 4; k++) drive(7, 6, 5, 1'b0, 1'b1, 1'b1, 3);
    line_start(3);
    drive(3, 3, 3, 1'b0, 1'b1, 1'b1, 3);
    total++;
    if ({vif.mode_o, vif_t.mode_o} !== 4'b0101) begin
      bad++; $display("FAIL switch_midframe got=%b want=0101", {vif.mode_o, vif_t.mode_o});
    end
    frame_start(3);
    total++;
    if (vif.mode_o !== 2'd3) begin
      bad++; $display("FAIL switch_vsync got=%0d want=3", vif.mode_o);
    end
    drive(3, 3, 3, 1'b0, 1'b1, 1'b1, 3);
    drive(7, 7, 7, 1'b1, 1'b1, 1'b1, 3);
    total++;
    if (vif.rgb_r_o !== 2'd1) begin
      bad++; $display("FAIL switch_dither got=%0d want=1", vif.rgb_r_o);
    end
    drive(0, 0, 0, 1'b1, 1'b1, 1'b1, 3);
    total++;
    if ({vif.rgb_r_o, vif.rgb_g_o, vif.rgb_b_o} !== 6'd0) begin
      bad++; $display("FAIL blank got=%h want=0", {vif.rgb_r_o, vif.rgb_g_o, vif.rgb_b_o});
    end
  endtask

  task automatic test_ce_reset();
    frame_start(2);
    idle(3);
    drive(5, 2, 7, 1'b0, 1'b1, 1'b1, 2);
    idle(3);
    line_start(2);
    idle(3);
    drive(6, 6, 6, 1'b0, 1'b0, 1'b1, 2);
    idle(1);
    vif.pix_ce_i = 1'b0;
    do_reset(1);
    total++;
    if ({vif.mode_o, vif_t.mode_o} !== 4'b0111) begin
      bad++; $display("FAIL ce_reset_mode got=%b want=0111", {vif.mode_o, vif_t.mode_o});
    end
    total++;
    if ({vif.hsync_o, vif.vsync_o, vif.rgb_r_o} !== 4'b1100) begin
      bad++; $display("FAIL ce_reset_out got=%b want=1100", {vif.hsync_o, vif.vsync_o, vif.rgb_r_o});
    end
    reset_i = 1'b0;
    idle(2);
    for (int k = 0; k < 4; k++) begin
      drive(3, 3, 3, 1'b0, 1'b1, 1'b1, 2);
      idle(3);
    end
    drive(0, 0, 0, 1'b1, 1'b1, 1'b1, 2);
    idle(3);
    drive(0, 0, 0, 1'b1, 1'b1, 1'b1, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    vif.pix_ce_i = 1'b0;
    vif.rgb_r_i  = 3'd0;
    vif.rgb_g_i  = 3'd0;
    vif.rgb_b_i  = 3'd0;
    vif.blank_i  = 1'b1;
    vif.hsync_i  = 1'b1;
    vif.vsync_i  = 1'b1;
    vif.mode_i   = 2'd1;
    model_reset();
    test_reset();
    test_latency();
    test_modes();
    test_dither();
    test_temporal();
    test_mode_switch();
    test_ce_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
